// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Posted-write buffer between the CPU memory stage and a
//            single-port data memory. Stores are queued in a circular FIFO
//            and retired to memory in cycles the CPU leaves the port free.
//            Loads search the buffer youngest-first.
// Ports    : clk, reset (sync, active-high)
//            cpu_addr/cpu_wdata/cpu_memW/cpu_memR  - CPU request
//            cpu_rdata (comb), stall (comb)         - CPU response
//            mem_address/mem_data/mem_memW/mem_memR - to memory
//            mem_readData                           - from memory
//            count (registered occupancy), empty
// Config   : STORE_BUF_FWD_EN - when defined, a load that matches a buffered
//            entry is answered from the youngest match. When undefined, such
//            a load stalls and drains the buffer until nothing matches.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          cpu_memW,
  input  logic          cpu_memR,
  output logic [31:0]   cpu_rdata,
  output logic          stall,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_data,
  output logic          mem_memW,
  output logic          mem_memR,
  input  logic [31:0]   mem_readData,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;

  logic          is_store;
  logic          is_load;
  logic          is_idle;
  logic          full;
  logic          match;
  logic [31:0]   match_data;
  logic [PW-1:0] idx;
  logic          fwd_hit;
  logic          load_block;
  logic          miss;
  logic          drain;
  logic          enq;

  // Both request lines high is treated the same as neither.
  assign is_store = cpu_memW && !cpu_memR;
  assign is_load  = cpu_memR && !cpu_memW;
  assign is_idle  = !is_store && !is_load;
  assign full     = (count_q == CW'(DEPTH));

  // Walk valid entries oldest to youngest so the last hit, i.e. the
  // youngest matching store, is the one that survives.
  always_comb begin
    match      = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == cpu_addr)) begin
        match      = 1'b1;
        match_data = data_q[idx];
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign fwd_hit    = is_load && match;
  assign load_block = 1'b0;
`else
  assign fwd_hit    = 1'b0;
  assign load_block = is_load && match;
`endif

  // A miss owns the memory port for the cycle; everything that touches
  // the port is suppressed while reset is high.
  assign miss  = !reset && is_load && !match;
  assign stall = !reset && ((is_store && full) || load_block);
  assign drain = !reset && (count_q != '0) && !miss &&
                 (is_idle || full || fwd_hit || stall);
  assign enq   = !reset && is_store && !full;

  always_comb begin
    mem_memW    = 1'b0;
    mem_memR    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (drain) begin
      mem_memW    = 1'b1;
      mem_address = addr_q[head];
      mem_data    = data_q[head];
    end else if (miss) begin
      mem_memR    = 1'b1;
      mem_address = cpu_addr;
    end
  end

  assign cpu_rdata = fwd_hit ? match_data : (miss ? mem_readData : 32'h0);

  assign count = count_q;
  assign empty = (count_q == '0);

  // Entry storage carries no reset: validity is defined by head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count_q <= count_q + CW'(enq) - CW'(drain);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer. A small memory model sits
//            on the memory port; every accepted store is pushed to a queue
//            and each drain seen on the port is popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_memW;
  logic          cpu_memR;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic [31:0]   mem_address;
  logic [31:0]   mem_data;
  logic          mem_memW;
  logic          mem_memR;
  logic [31:0]   mem_readData;
  logic [CW-1:0] count;
  logic          empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memW     (cpu_memW),
    .cpu_memR     (cpu_memR),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_memW     (mem_memW),
    .mem_memR     (mem_memR),
    .mem_readData (mem_readData),
    .count        (count),
    .empty        (empty)
  );

  // Memory model: combinational read, write on the clock edge.
  assign mem_readData = mem[mem_address[5:0]];
  always @(posedge clk) begin
    if (mem_memW) mem[mem_address[5:0]] <= mem_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a store seen un-stalled at the falling edge is accepted on
  // the next rising edge; every drain must match the oldest accepted store.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (mem_memW) begin
        if (sb_q.size() == 0) check("drain_unexpected", {mem_address, mem_data}, 64'h0);
        else check("drain_order", {mem_address, mem_data}, sb_q.pop_front());
        check("port_excl", {63'h0, mem_memR}, 64'h0);
      end
      if (cpu_memW && !cpu_memR && !stall) sb_q.push_back({cpu_addr, cpu_wdata});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    cpu_memW  = w;
    cpu_memR  = r;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic drain_all(input string tag);
    int n;
    n = 0;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    while (count != 0 && n < 2 * DEPTH + 2) begin
      step();
      n++;
    end
    @(negedge clk);
    check(tag, {63'h0, empty}, 64'h1);
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[9] = 32'h77;
    reset  = 1'b1;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_count", 64'(count), 64'h0);
    check("rst_empty", {63'h0, empty}, 64'h1);
    check("rst_stall", {63'h0, stall}, 64'h0);
    step();

    // Single store then idle
    req(1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("st1_nodrain", {63'h0, mem_memW}, 64'h0);
    step();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("st1_memW", {63'h0, mem_memW}, 64'h1);
    check("st1_addr", 64'(mem_address), 64'd5);
    check("st1_data", 64'(mem_data), 64'hDEADBEEF);
    check("st1_count", 64'(count), 64'h1);
    step();
    @(negedge clk);
    check("st1_count_after", 64'(count), 64'h0);
    check("st1_mem", 64'(mem[5]), 64'hDEADBEEF);
    step();

    // Fill the buffer back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b1, 1'b0, 32'(i), 32'h100 + 32'(i));
      @(negedge clk);
      check("fill_nodrain", {63'h0, mem_memW}, 64'h0);
      check("fill_nostall", {63'h0, stall}, 64'h0);
      step();
    end
    req(1'b1, 1'b0, 32'd4, 32'h104);
    @(negedge clk);
    check("full_count", 64'(count), 64'd4);
    check("full_stall", {63'h0, stall}, 64'h1);
    check("full_memW", {63'h0, mem_memW}, 64'h1);
    check("full_addr", 64'(mem_address), 64'h0);
    step();
    @(negedge clk);
    check("full_retry_stall", {63'h0, stall}, 64'h0);
    check("full_retry_count", 64'(count), 64'd3);
    step();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("full_accept_count", 64'(count), 64'd4);
    drain_all("full_drained");

    // Two stores to the same address, then a load of it
    req(1'b1, 1'b0, 32'd8, 32'h11);
    step();
    req(1'b1, 1'b0, 32'd8, 32'h22);
    step();
    req(1'b0, 1'b1, 32'd8, 32'h0);
    @(negedge clk);
`ifdef STORE_BUF_FWD_EN
    check("fwd_rdata", 64'(cpu_rdata), 64'h22);
    check("fwd_memR", {63'h0, mem_memR}, 64'h0);
    check("fwd_stall", {63'h0, stall}, 64'h0);
    check("fwd_count", 64'(count), 64'd2);
    step();
`else
    for (int c = 0; c < 2; c++) begin
      check("nofwd_stall", {63'h0, stall}, 64'h1);
      check("nofwd_memR", {63'h0, mem_memR}, 64'h0);
      check("nofwd_rdata", 64'(cpu_rdata), 64'h0);
      check("nofwd_count", 64'(count), 64'(2 - c));
      step();
      @(negedge clk);
    end
    check("nofwd_released", {63'h0, stall}, 64'h0);
    check("nofwd_miss_memR", {63'h0, mem_memR}, 64'h1);
    check("nofwd_miss_rdata", 64'(cpu_rdata), 64'h22);
    step();
`endif
    drain_all("fwd_drained");

    // Load miss with an unrelated entry buffered
    req(1'b1, 1'b0, 32'd8, 32'h33);
    step();
    req(1'b0, 1'b1, 32'd9, 32'h0);
    @(negedge clk);
    check("miss_memR", {63'h0, mem_memR}, 64'h1);
    check("miss_memW", {63'h0, mem_memW}, 64'h0);
    check("miss_addr", 64'(mem_address), 64'd9);
    check("miss_rdata", 64'(cpu_rdata), 64'h77);
    step();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("miss_count", 64'(count), 64'd1);
    check("idle_rdata", 64'(cpu_rdata), 64'h0);
    drain_all("miss_drained");

    // Load miss while full: the load keeps the port
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b1, 1'b0, 32'd16 + 32'(i), 32'h200 + 32'(i));
      step();
    end
    req(1'b0, 1'b1, 32'd9, 32'h0);
    @(negedge clk);
    check("fullmiss_memR", {63'h0, mem_memR}, 64'h1);
    check("fullmiss_memW", {63'h0, mem_memW}, 64'h0);
    check("fullmiss_stall", {63'h0, stall}, 64'h0);
    check("fullmiss_count", 64'(count), 64'd4);
    step();
    drain_all("fullmiss_drained");

    // Reset with three entries pending: nothing reaches memory
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b0, 32'd40 + 32'(i), 32'h300 + 32'(i));
      step();
    end
    req(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_memW", {63'h0, mem_memW}, 64'h0);
    check("midrst_stall", {63'h0, stall}, 64'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_count", 64'(count), 64'h0);
    check("midrst_empty", {63'h0, empty}, 64'h1);
    check("midrst_nodrain", {63'h0, mem_memW}, 64'h0);
    step();
    step();
    check("midrst_mem40", 64'(mem[40]), 64'h0);
    check("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
